// File: rtl/lfsr_deinterleaver.sv
// lfsr_deinterleaver: receive-side companion of the LFSR interleaver.
// Incoming words are written to the address produced by the same LFSR
// sequence the interleaver used; once a full frame (2^ADDR_W words) is
// stored, the RAM is read out sequentially to restore the original order.
// The final word of a frame always lands at address 0, because the LFSR
// never produces the all-zero state.
//
// Optional feature macro: DEINT_ERR_EN
//   When defined, adds the sticky outputs err and err_code:
//     err_code[0] : a word was presented while not filling (dropped)
//     err_code[1] : st was asserted while busy (ignored)
//     err         : |err_code
//   Both are cleared only by rst.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer keeps data stable while valid is high and
// ready is low; ready never depends combinationally on valid.
module lfsr_deinterleaver #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter logic [ADDR_W-1:0] TAP_MASK = 14'h3802,
  parameter logic [ADDR_W-1:0] SEED = 14'h0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done
`ifdef DEINT_ERR_EN
  ,
  output logic              err,
  output logic [1:0]        err_code
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t            state;
  logic [ADDR_W-1:0] lfsr;
  logic [ADDR_W-1:0] wcnt;
  logic [ADDR_W-1:0] raddr;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] lfsr_next;
  logic              rd_en;
  logic              last_take;

  // Status outputs come straight from the state register.
  assign in_ready = (state == S_FILL);
  assign busy     = (state != S_IDLE);

  // Write side: the terminal word of a frame goes to address 0.
  assign wr_en     = (state == S_FILL) && in_valid;
  assign wr_addr   = (wcnt == ADDR_LAST) ? '0 : lfsr;
  assign lfsr_next = {lfsr[ADDR_W-2:0], ^(lfsr & TAP_MASK)};

  // Read side: fetch the next word whenever the output register is free
  // or being emptied, and stop once the last word has been fetched.
  assign rd_en     = (state == S_DRAIN) && (!out_valid || out_ready) && !out_last;
  assign last_take = (state == S_DRAIN) && out_valid && out_ready && out_last;

  // Frame buffer write port (contents survive reset).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= in_data;
    end
  end

  // Control FSM: fill addressing, sequential drain and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      lfsr       <= SEED;
      wcnt       <= '0;
      raddr      <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (st) begin
            state <= S_FILL;
          end
        end
        S_FILL: begin
          if (in_valid) begin
            if (wcnt == ADDR_LAST) begin
              state <= S_DRAIN;
              lfsr  <= SEED;
              wcnt  <= '0;
            end else begin
              lfsr <= lfsr_next;
              wcnt <= wcnt + ADDR_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (rd_en) begin
            out_data  <= mem[raddr];
            out_valid <= 1'b1;
            out_last  <= (raddr == ADDR_LAST);
            raddr     <= raddr + ADDR_W'(1);
          end else if (last_take) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b1;
            raddr      <= '0;
            state      <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DEINT_ERR_EN
  // Sticky protocol error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_code <= 2'b00;
    end else begin
      if (in_valid && (state != S_FILL)) begin
        err_code[0] <= 1'b1;
      end
      if (st && (state != S_IDLE)) begin
        err_code[1] <= 1'b1;
      end
    end
  end

  assign err = |err_code;
`endif

endmodule

// File: tb/tb_lfsr_deinterleaver.sv
// Directed bench for lfsr_deinterleaver in a 16-word configuration
// (ADDR_W=4, TAP_MASK=4'hC, SEED=1). The write-address table below is the
// hand-computed LFSR sequence; expected output order is derived from it.
module tb_lfsr_deinterleaver;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NW     = 16;

  typedef struct {
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] waddr;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              st;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              frame_done;
`ifdef DEINT_ERR_EN
  logic              err;
  logic [1:0]        err_code;
`endif

  vec_t              vecs [NW];
  logic [DATA_W-1:0] exp_q [$];
  int                n_vec  = 0;
  int                n_miss = 0;

  lfsr_deinterleaver #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TAP_MASK(4'hC),
    .SEED    (4'h1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .st        (st),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .frame_done(frame_done)
`ifdef DEINT_ERR_EN
    ,
    .err       (err),
    .err_code  (err_code)
`endif
  );

  // Clock: 10 ns period; inputs driven and outputs sampled on the falling edge.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Assign data for a frame and build the expected output order:
  // output position a carries the word that was written to address a.
  task automatic build_frame(input logic [DATA_W-1:0] base);
    exp_q.delete();
    for (int k = 0; k < NW; k++) begin
      vecs[k].din = base + DATA_W'(k);
    end
    for (int a = 0; a < NW; a++) begin
      for (int k = 0; k < NW; k++) begin
        if (int'(vecs[k].waddr) == a) exp_q.push_back(vecs[k].din);
      end
    end
  endtask

  // Pulse st, then deliver nwords words with random idle gaps up to max_gap.
  task automatic fill_frame(input int nwords, input int max_gap);
    int wait_cnt;
    @(negedge clk); st = 1'b1;
    @(negedge clk); st = 1'b0;
    for (int k = 0; k < nwords; k++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = vecs[k].din;
      wait_cnt = 0;
      while (!in_ready && wait_cnt < 20) begin
        @(negedge clk);
        wait_cnt++;
      end
      if (!in_ready) check("fill_in_ready_timeout", 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = '0;
    if (nwords == NW) begin
      check("in_ready_after_last_write", 32'(in_ready), 32'd0);
      check("busy_in_drain", 32'(busy), 32'd1);
      check("out_valid_drain_entry", 32'(out_valid), 32'd0);
    end
  endtask

  // Drain one frame. mode 0: out_ready held high (gapless check).
  // mode 1: out_ready toggles, 5-cycle stall mid-frame, plus a stray st and
  // stray input words that must be ignored.
  task automatic drain_frame(input int mode);
    int                got;
    int                cyc;
    int                stall_cnt;
    bit                stalled;
    logic [DATA_W-1:0] held_data;
    logic              held_last;
    logic [DATA_W-1:0] exp_w;
    got = 0; cyc = 0; stall_cnt = 0; stalled = 1'b0;
    held_data = '0; held_last = 1'b0;
    while (got < NW && cyc < 200) begin
      if (mode == 0) begin
        out_ready = 1'b1;
        check("gapless_out_valid", 32'(out_valid), (cyc >= 1) ? 32'd1 : 32'd0);
      end else begin
        st       = (cyc == 3);
        in_valid = (cyc >= 4 && cyc <= 6);
        in_data  = 32'hDEAD_0000 + DATA_W'(cyc);
        if (got == 8 && stall_cnt < 5) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else begin
          out_ready = cyc[0];
        end
      end
      if (out_valid) begin
        if (stalled) begin
          check("stall_data_stable", out_data, held_data);
          check("stall_last_stable", 32'(out_last), 32'(held_last));
        end
        if (out_ready) begin
          exp_w = exp_q.pop_front();
          check($sformatf("out_word_%0d", got), out_data, exp_w);
          check($sformatf("out_last_%0d", got), 32'(out_last), (got == NW-1) ? 32'd1 : 32'd0);
          got++;
          stalled = 1'b0;
        end else begin
          stalled   = 1'b1;
          held_data = out_data;
          held_last = out_last;
        end
      end
      @(negedge clk);
      cyc++;
    end
    st = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    if (got < NW) check("drain_timeout", 32'(got), 32'(NW));
    check("frame_done_pulse", 32'(frame_done), 32'd1);
    check("out_valid_after_frame", 32'(out_valid), 32'd0);
    check("busy_after_frame", 32'(busy), 32'd0);
    @(negedge clk);
    check("frame_done_one_cycle", 32'(frame_done), 32'd0);
  endtask

  initial begin
    // Write addresses of handshakes 0..15 for x^4+x^3+1, seed 1.
    int unsigned waddr_tab [NW] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 0};
    for (int k = 0; k < NW; k++) vecs[k].waddr = ADDR_W'(waddr_tab[k]);

    rst = 1'b1; st = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
`ifdef DEINT_ERR_EN
    check("rst_err_code", 32'(err_code), 32'd0);
`endif

    // Words offered in IDLE are dropped without leaving IDLE.
    in_valid = 1'b1; in_data = 32'hBAD0_BAD0;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("idle_drop_busy", 32'(busy), 32'd0);
    check("idle_drop_in_ready", 32'(in_ready), 32'd0);

    // Scenario 1: back-to-back fill, ready held high.
    build_frame(32'hA000_0000);
    check("exp_first_word", exp_q[0], 32'hA000_000F);
    fill_frame(NW, 0);
    drain_frame(0);
`ifdef DEINT_ERR_EN
    check("err_code_after_idle_drop", 32'(err_code), 32'd1);
`endif

    // Scenario 2: toggling/stalled out_ready with stray st and words.
    build_frame(32'hC100_0000);
    fill_frame(NW, 0);
    drain_frame(1);
`ifdef DEINT_ERR_EN
    check("err_code_sticky", 32'(err_code), 32'd3);
    check("err_flag", 32'(err), 32'd1);
`endif

    // Scenario 3: random input gaps, same ordering as scenario 1.
    build_frame(32'hA000_0000);
    fill_frame(NW, 3);
    drain_frame(0);

    // Scenario 4: reset after 7 writes, then a clean frame.
    build_frame(32'hEE00_0000);
    fill_frame(7, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midfill_rst_busy", 32'(busy), 32'd0);
    check("midfill_rst_out_valid", 32'(out_valid), 32'd0);
    check("midfill_rst_in_ready", 32'(in_ready), 32'd0);
`ifdef DEINT_ERR_EN
    check("err_code_cleared", 32'(err_code), 32'd0);
`endif
    build_frame(32'hB000_0000);
    fill_frame(NW, 0);
    drain_frame(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
